platform_bank: RTL and testbench

//  Parametrised platform store for the game core. It replaces the fixed set of 15 platX/platY

---
 rtl/doodle_pkg.sv | 36 +++
 rtl/lfsr16.sv | 22 ++
 rtl/platform_bank.sv | 228 ++++++++++++++++++++++
 tb/tb_platform_bank.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// Geometry defaults, the platform record and the frame-update states shared by the game core.
// Also holds the span test and reset-layout helpers used by the platform bank.
package doodle_pkg;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;
    localparam int PLAT_W_DEF   = 60;
    localparam int PLAT_H_DEF   = 8;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } plat_t;

    typedef enum logic [1:0] {
        PB_IDLE,
        PB_SCAN,
        PB_DONE
    } pb_state_t;

    // lo <= v < lo+len; 11 bits so lo+len never wraps for on-screen values.
    function automatic logic in_span(input logic [10:0] v,
                                     input logic [10:0] lo,
                                     input logic [10:0] len);
        return (v >= lo) && (v < lo + len);
    endfunction

    function automatic logic [9:0] init_y(input int i, input int n, input int h);
        return 10'(i * (h / n));
    endfunction

    function automatic logic [9:0] init_x(input int i, input int w, input int pw);
        return 10'((i * 97) % (w - pw));
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11) that picks respawn positions.
// Latency: q advances one state on the cycle after step; no backpressure, step is a plain enable.
// Reset loads seed, which must be nonzero.
module lfsr16 (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    localparam logic [15:0] TAPS = 16'hB400;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q <= seed;
        end else if (step) begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/platform_bank.sv
// Platform register bank: per-frame scroll/respawn sweep plus registered pixel and landing queries.
// Latency: queries 1 cycle; frame update NUM_PLAT+1 cycles after tick. A tick while busy is dropped (overrun).
// PLAT_MOVE_EN: odd slots also drift horizontally by 1 px per frame and bounce at the screen edges.
module platform_bank
    import doodle_pkg::*;
#(
    parameter int          NUM_PLAT  = 16,
    parameter int          SCREEN_W  = SCREEN_W_DEF,
    parameter int          SCREEN_H  = SCREEN_H_DEF,
    parameter int          PLAT_W    = PLAT_W_DEF,
    parameter int          PLAT_H    = PLAT_H_DEF,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  scroll_amt,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  DoodleX,
    input  logic [9:0]  DoodleY,
    input  logic [9:0]  Doodle_size,
    input  logic        doodle_falling,
    output logic        plat_on,
    output logic        landed,
    output logic [9:0]  land_y,
    output logic        busy,
    output logic        upd_done,
    output logic        overrun,
    output logic [15:0] respawn_cnt
);

    localparam int               IDX_W    = $clog2(NUM_PLAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAT - 1);
    localparam logic [10:0]      H11      = 11'(SCREEN_H);
    localparam logic [10:0]      PW11     = 11'(PLAT_W);
    localparam logic [10:0]      PH11     = 11'(PLAT_H);
    localparam logic [9:0]       X_SPAN   = 10'(SCREEN_W - PLAT_W);

    plat_t            plat_q [NUM_PLAT];
    pb_state_t        state_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       amt_q;

    logic [2:0]       fsync_q;
    logic             tick;

    logic [15:0]      lfsr_q;
    logic             lfsr_step;
    logic             unused_lfsr_hi;

    plat_t            cur;
    logic [10:0]      y_sum;
    logic             wrap;
    logic [9:0]       y_next;
    logic [9:0]       x_next;
    logic [9:0]       r;
    logic [9:0]       rx;

`ifdef PLAT_MOVE_EN
    localparam logic [9:0] X_MAX = X_SPAN - 10'd1;
    logic [NUM_PLAT-1:0] dir_q;
    logic                dir_next;
`endif

    logic [10:0]      feet;
    logic [10:0]      doodle_r;
    logic             pix_hit;
    logic             land_hit;
    logic [9:0]       land_y_c;

    // frame_clk is a foreign-domain vsync: two sync flops, the third holds the previous sample.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fsync_q <= '0;
        end else begin
            fsync_q <= {fsync_q[1:0], frame_clk};
        end
    end

    assign tick = fsync_q[1] & ~fsync_q[2];

    assign lfsr_step      = (state_q == PB_SCAN) && wrap;
    assign unused_lfsr_hi = ^lfsr_q[15:10];

    lfsr16 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .step  (lfsr_step),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Next state of the slot under the scan pointer.
    always_comb begin
        cur      = plat_q[idx_q];
        y_sum    = {1'b0, cur.y} + {3'b000, amt_q};
        wrap     = (y_sum >= H11);
        y_next   = 10'(wrap ? y_sum - H11 : y_sum);
        r        = lfsr_q[9:0];
        rx       = (r >= X_SPAN) ? r - X_SPAN : r;
        x_next   = cur.x;
`ifdef PLAT_MOVE_EN
        dir_next = dir_q[idx_q];
        if (idx_q[0]) begin
            if (!dir_q[idx_q]) begin
                if (cur.x >= X_MAX) begin
                    dir_next = 1'b1;
                    x_next   = cur.x - 10'd1;
                end else begin
                    x_next   = cur.x + 10'd1;
                end
            end else begin
                if (cur.x == 10'd0) begin
                    dir_next = 1'b0;
                    x_next   = 10'd1;
                end else begin
                    x_next   = cur.x - 10'd1;
                end
            end
        end
        if (wrap) begin
            dir_next = lfsr_q[0];
        end
`endif
        if (wrap) begin
            x_next = rx;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= PB_IDLE;
            idx_q       <= '0;
            amt_q       <= '0;
            busy        <= 1'b0;
            upd_done    <= 1'b0;
            overrun     <= 1'b0;
            respawn_cnt <= '0;
            for (int i = 0; i < NUM_PLAT; i++) begin
                plat_q[i].x <= init_x(i, SCREEN_W, PLAT_W);
                plat_q[i].y <= init_y(i, NUM_PLAT, SCREEN_H);
            end
`ifdef PLAT_MOVE_EN
            dir_q <= '0;
`endif
        end else begin
            if (tick && (state_q != PB_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state_q)
                PB_IDLE: begin
                    upd_done <= 1'b0;
                    if (tick) begin
                        amt_q   <= scroll_amt;
                        idx_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= PB_SCAN;
                    end
                end
                PB_SCAN: begin
                    plat_q[idx_q].y <= y_next;
                    plat_q[idx_q].x <= x_next;
`ifdef PLAT_MOVE_EN
                    dir_q[idx_q] <= dir_next;
`endif
                    if (wrap) begin
                        respawn_cnt <= respawn_cnt + 16'd1;
                    end
                    if (idx_q == LAST_IDX) begin
                        upd_done <= 1'b1;
                        state_q  <= PB_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                PB_DONE: begin
                    upd_done <= 1'b0;
                    busy     <= 1'b0;
                    state_q  <= PB_IDLE;
                end
                default: begin
                    upd_done <= 1'b0;
                    busy     <= 1'b0;
                    state_q  <= PB_IDLE;
                end
            endcase
        end
    end

    assign feet     = {1'b0, DoodleY} + {1'b0, Doodle_size};
    assign doodle_r = {1'b0, DoodleX} + {1'b0, Doodle_size};

    // Walk slots high to low so the lowest matching index sets land_y last.
    always_comb begin
        pix_hit  = 1'b0;
        land_hit = 1'b0;
        land_y_c = '0;
        for (int i = NUM_PLAT - 1; i >= 0; i--) begin
            if (in_span({1'b0, DrawX}, {1'b0, plat_q[i].x}, PW11) &&
                in_span({1'b0, DrawY}, {1'b0, plat_q[i].y}, PH11)) begin
                pix_hit = 1'b1;
            end
            if (doodle_falling &&
                in_span(feet, {1'b0, plat_q[i].y}, PH11) &&
                (doodle_r > {1'b0, plat_q[i].x}) &&
                ({1'b0, DoodleX} < {1'b0, plat_q[i].x} + PW11 + {1'b0, Doodle_size})) begin
                land_hit = 1'b1;
                land_y_c = plat_q[i].y;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            plat_on <= 1'b0;
            landed  <= 1'b0;
            land_y  <= '0;
        end else begin
            plat_on <= pix_hit;
            landed  <= land_hit;
            if (land_hit) begin
                land_y <= land_y_c;
            end
        end
    end

endmodule

// File: tb/tb_platform_bank.sv
// Directed bench for platform_bank with the default 16-slot layout.
// Slot i starts at Y=i*30, X=(i*97)%580; e.g. slot 2 (194,60), slot 3 (291,90), slot 15 (295,450).
module tb_platform_bank;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [7:0]  scroll_amt = '0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [9:0]  DoodleX = '0;
    logic [9:0]  DoodleY = '0;
    logic [9:0]  Doodle_size = '0;
    logic        doodle_falling = 1'b0;
    logic        plat_on;
    logic        landed;
    logic [9:0]  land_y;
    logic        busy;
    logic        upd_done;
    logic        overrun;
    logic [15:0] respawn_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    platform_bank dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .scroll_amt     (scroll_amt),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .DoodleX        (DoodleX),
        .DoodleY        (DoodleY),
        .Doodle_size    (Doodle_size),
        .doodle_falling (doodle_falling),
        .plat_on        (plat_on),
        .landed         (landed),
        .land_y         (land_y),
        .busy           (busy),
        .upd_done       (upd_done),
        .overrun        (overrun),
        .respawn_cnt    (respawn_cnt)
    );

    always #10 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic probe_pix(input logic [9:0] x, input logic [9:0] y, output logic v);
        @(negedge Clk);
        DrawX = x;
        DrawY = y;
        @(negedge Clk);
        v = plat_on;
    endtask

    task automatic probe_land(input logic [9:0] dx, input logic [9:0] dy, input logic fall,
                              output logic l, output logic [9:0] ly);
        @(negedge Clk);
        DoodleX        = dx;
        DoodleY        = dy;
        doodle_falling = fall;
        @(negedge Clk);
        l  = landed;
        ly = land_y;
    endtask

    // One frame: raise frame_clk, measure edge-to-busy latency, busy length and upd_done pulses.
    task automatic run_frame(input logic [7:0] amt, output int lat, output int nbusy,
                             output int ndone, output logic last_done);
        lat = 0; nbusy = 0; ndone = 0; last_done = 1'b0;
        @(negedge Clk);
        scroll_amt = amt;
        frame_clk  = 1'b1;
        while (!busy && lat < 8) begin
            @(negedge Clk);
            lat++;
        end
        while (busy && nbusy < 64) begin
            nbusy++;
            last_done = upd_done;
            if (upd_done) ndone++;
            @(negedge Clk);
        end
        if (upd_done) ndone++;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic pulse_frame(input logic [7:0] amt);
        int guard;
        guard = 0;
        @(negedge Clk);
        scroll_amt = amt;
        frame_clk  = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        while (busy && guard < 40) begin
            @(negedge Clk);
            guard++;
        end
        @(negedge Clk);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        DrawX = 10'd639;
        DrawY = 10'd479;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if ({plat_on, landed, busy, upd_done, overrun} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000", {plat_on, landed, busy, upd_done, overrun});
        end
        n_cmp++;
        if (respawn_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_respawn_cnt: got %0d want 0", respawn_cnt);
        end
        n_cmp++;
        if (land_y !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_land_y: got %0d want 0", land_y);
        end
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if ({plat_on, landed, busy, upd_done, overrun} !== 5'b0) begin
            n_bad++;
            $display("FAIL post_reset_flags: got %b want 00000", {plat_on, landed, busy, upd_done, overrun});
        end
    endtask

    task automatic test_pixel;
        logic [9:0] vx [8] = '{10'd291, 10'd350, 10'd351, 10'd291, 10'd290, 10'd0, 10'd60, 10'd59};
        logic [9:0] vy [8] = '{10'd90,  10'd97,  10'd90,  10'd98,  10'd90,  10'd0, 10'd0,  10'd7};
        logic       ve [8] = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b0,    1'b1,  1'b0,   1'b1};
        logic v;
        for (int i = 0; i < 8; i++) begin
            probe_pix(vx[i], vy[i], v);
            n_cmp++;
            if (v !== ve[i]) begin
                n_bad++;
                $display("FAIL pixel[%0d] (%0d,%0d): plat_on=%b want %b", i, vx[i], vy[i], v, ve[i]);
            end
        end
    endtask

    // Slot 3 at (291,90), doodle size 14: feet must land in [90,98), X in (277,365).
    task automatic test_landing;
        logic [9:0] dx [9] = '{10'd300, 10'd300, 10'd300, 10'd300, 10'd278, 10'd277, 10'd364, 10'd365, 10'd300};
        logic [9:0] dy [9] = '{10'd76,  10'd83,  10'd84,  10'd75,  10'd76,  10'd76,  10'd76,  10'd76,  10'd76};
        logic       df [9] = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b0};
        logic       le [9] = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b0};
        logic       l;
        logic [9:0] ly;
        Doodle_size = 10'd14;
        for (int i = 0; i < 9; i++) begin
            probe_land(dx[i], dy[i], df[i], l, ly);
            n_cmp++;
            if (l !== le[i]) begin
                n_bad++;
                $display("FAIL landed[%0d] (%0d,%0d,f=%b): got %b want %b", i, dx[i], dy[i], df[i], l, le[i]);
            end
            n_cmp++;
            if (ly !== 10'd90) begin
                n_bad++;
                $display("FAIL land_y[%0d]: got %0d want 90", i, ly);
            end
        end
        doodle_falling = 1'b0;
    endtask

    task automatic test_frame_update;
        int lat, nbusy, ndone;
        logic last_done, v;
        run_frame(8'd5, lat, nbusy, ndone, last_done);
        n_cmp++;
        if (lat < 1 || lat > 4) begin
            n_bad++;
            $display("FAIL tick_latency: got %0d cycles want 1..4", lat);
        end
        n_cmp++;
        if (nbusy != 17) begin
            n_bad++;
            $display("FAIL busy_cycles: got %0d want 17", nbusy);
        end
        n_cmp++;
        if (ndone != 1 || last_done !== 1'b1) begin
            n_bad++;
            $display("FAIL upd_done_pulse: got count %0d last %b want 1 and 1", ndone, last_done);
        end
        n_cmp++;
        if (respawn_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL frame_respawn_cnt: got %0d want 0", respawn_cnt);
        end
        probe_pix(10'd194, 10'd65, v);
        n_cmp++;
        if (v !== 1'b1) begin
            n_bad++;
            $display("FAIL scrolled_top: plat_on=%b want 1", v);
        end
        probe_pix(10'd194, 10'd64, v);
        n_cmp++;
        if (v !== 1'b0) begin
            n_bad++;
            $display("FAIL scrolled_above: plat_on=%b want 0", v);
        end
    endtask

    task automatic test_respawn;
        int lat, nbusy, ndone;
        logic last_done, v;
        logic [9:0] px [6] = '{10'd225, 10'd224, 10'd284, 10'd285, 10'd300, 10'd194};
        logic [9:0] py [6] = '{10'd5,   10'd5,   10'd12,  10'd5,   10'd476, 10'd95};
        logic       pe [6] = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b0,    1'b1};
        run_frame(8'd20, lat, nbusy, ndone, last_done);
        n_cmp++;
        if (respawn_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL pre_respawn_cnt: got %0d want 0", respawn_cnt);
        end
        probe_pix(10'd300, 10'd475, v);
        n_cmp++;
        if (v !== 1'b1) begin
            n_bad++;
            $display("FAIL slot15_at_475: plat_on=%b want 1", v);
        end
        run_frame(8'd10, lat, nbusy, ndone, last_done);
        n_cmp++;
        if (respawn_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL respawn_cnt: got %0d want 1", respawn_cnt);
        end
        // Seed 16'hACE1: low 10 bits are 225, below 580, so slot 15 reappears at X=225, Y=485-480=5.
        for (int i = 0; i < 6; i++) begin
            probe_pix(px[i], py[i], v);
            n_cmp++;
            if (v !== pe[i]) begin
                n_bad++;
                $display("FAIL respawn_pix[%0d] (%0d,%0d): plat_on=%b want %b", i, px[i], py[i], v, pe[i]);
            end
        end
    endtask

    task automatic test_overrun;
        int ndone;
        logic v;
        logic [9:0] py [4] = '{10'd98, 10'd97, 10'd105, 10'd106};
        logic       pe [4] = '{1'b1,   1'b0,   1'b1,    1'b0};
        ndone = 0;
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_idle: got %b want 0", overrun);
        end
        @(negedge Clk);
        scroll_amt = 8'd3;
        frame_clk  = 1'b1;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (upd_done) ndone++;
        end
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_set: got %b want 1", overrun);
        end
        n_cmp++;
        if (ndone != 1) begin
            n_bad++;
            $display("FAIL overrun_updates: got %0d want 1", ndone);
        end
        // Slot 2 Y: 60+5+20+10+3 = 98; a second update would put it at 101.
        for (int i = 0; i < 4; i++) begin
            probe_pix(10'd194, py[i], v);
            n_cmp++;
            if (v !== pe[i]) begin
                n_bad++;
                $display("FAIL overrun_pix[%0d] (194,%0d): plat_on=%b want %b", i, py[i], v, pe[i]);
            end
        end
    endtask

    task automatic test_reset_mid_update;
        int guard, lat, nbusy, ndone;
        logic last_done, v;
        guard = 0;
        @(negedge Clk);
        scroll_amt = 8'd50;
        frame_clk  = 1'b1;
        while (!busy && guard < 8) begin
            @(negedge Clk);
            guard++;
        end
        repeat (5) @(negedge Clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_busy: got %b want 1", busy);
        end
        Reset     = 1'b1;
        frame_clk = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if ({busy, upd_done, overrun} !== 3'b000 || respawn_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_reset_state: got busy/done/ovr %b cnt %0d want 000 0",
                     {busy, upd_done, overrun}, respawn_cnt);
        end
        probe_pix(10'd291, 10'd90, v);
        n_cmp++;
        if (v !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_layout: plat_on=%b want 1", v);
        end
        run_frame(8'd5, lat, nbusy, ndone, last_done);
        n_cmp++;
        if (nbusy != 17 || ndone != 1) begin
            n_bad++;
            $display("FAIL after_reset_frame: busy %0d done %0d want 17 1", nbusy, ndone);
        end
    endtask

`ifdef PLAT_MOVE_EN
    // Slot 1 starts at X=97 moving right; with zero scroll it reaches 578 after 481 frames.
    task automatic test_move;
        logic v;
        logic [9:0] px [6] = '{10'd579, 10'd578, 10'd638, 10'd578, 10'd637, 10'd638};
        logic       pe [6] = '{1'b1,    1'b0,    1'b1,    1'b1,    1'b1,    1'b0};
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        for (int f = 0; f < 481; f++) pulse_frame(8'd0);
        probe_pix(10'd578, 10'd30, v);
        n_cmp++;
        if (v !== 1'b1) begin
            n_bad++;
            $display("FAIL move_578: plat_on=%b want 1", v);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || i == 3) pulse_frame(8'd0);
            probe_pix(px[i], 10'd30, v);
            n_cmp++;
            if (v !== pe[i]) begin
                n_bad++;
                $display("FAIL move_pix[%0d] (%0d,30): plat_on=%b want %b", i, px[i], v, pe[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pixel();
        test_landing();
        test_frame_update();
        test_respawn();
        test_overrun();
        test_reset_mid_update();
`ifdef PLAT_MOVE_EN
        test_move();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
